// File: rtl/posit_pkg.sv
// Shared posit<16,1> constants and pipeline stage records for the fp32 -> posit return path.
package posit_pkg;

   localparam logic [15:0] P16_NAR    = 16'h8000;
   localparam logic [15:0] P16_MAXPOS = 16'h7FFF;
   localparam logic [15:0] P16_MINPOS = 16'h0001;
   localparam int          P16_ES     = 1;
   localparam int          FP32_BIAS  = 127;

   typedef enum logic [2:0] {
      CLS_NORM,
      CLS_NAR,
      CLS_ZERO,
      CLS_MAX,
      CLS_MIN
   } cls_t;

   // S1 -> S2 record: classification plus the raw fields the body is assembled from.
   typedef struct packed {
      cls_t               cls;
      logic               sign;
      logic signed [6:0]  k;
      logic               e;
      logic [22:0]        mant;
   } s1_rec_t;

   typedef struct packed {
      logic        neg;
      logic [15:0] mag;
      logic [2:0]  flags;
   } s2_rec_t;

endpackage

// File: rtl/reg16_enc.sv
// Posit<16,1> regime builder: signed run value k -> left-aligned regime bits and their length.
// Inverse of the regime decoder used on the posit -> fp32 side.
module reg16_enc (
   input  logic signed [6:0] k,
   output logic [14:0]       regime,
   output logic [4:0]        len
);

   logic [6:0] run;

   // k >= 0 emits (k+1) ones then a zero; k < 0 emits (-k) zeros then a one.
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      run    = '0;
      regime = '0;
      if (!k[6]) begin
         run    = $unsigned(k) + 7'd1;
         regime = ~(15'h7FFF >> run);
      end else begin
         run    = $unsigned(-k);
         regime = 15'h4000 >> run;
      end
      len = 5'(run + 7'd1);
   end

endmodule

// File: rtl/fp32_p161.sv
// Three-stage valid/ready converter from IEEE-754 binary32 to posit<16,1> with round-to-nearest-even.
// S1 classifies and splits scale into regime/exponent, S2 assembles and rounds, S3 applies the sign.
module fp32_p161
   import posit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_fp32,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_p16,
   output logic [2:0]  out_flags
);

   logic              adv;
   logic              v1, v2;
   s1_rec_t           s1_d, s1_q;
   s2_rec_t           s2_d, s2_q;
   logic [7:0]        exp_f;
   logic signed [9:0] scale;
   logic [14:0]       regime;
   logic [4:0]        reg_len;
   logic [63:0]       body_vec;
   logic [14:0]       body;
   logic              guard, sticky;
   logic [15:0]       rnd;
   logic              exact_max;

   // The whole pipe moves as one; a stalled output freezes every stage.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   assign exp_f = in_fp32[30:23];
   assign scale = $signed({2'b00, exp_f}) - $signed(10'(FP32_BIAS));

   always_comb begin
      s1_d      = '0;
      s1_d.sign = in_fp32[31];
      s1_d.k    = 7'(scale >>> 1);
      s1_d.e    = scale[0];
      s1_d.mant = in_fp32[22:0];
      if (exp_f == 8'hFF)           s1_d.cls = CLS_NAR;
      else if (exp_f == 8'h00)      s1_d.cls = CLS_ZERO;
      else if (scale >= 10'sd28)    s1_d.cls = CLS_MAX;
      else if (scale < -10'sd28)    s1_d.cls = CLS_MIN;
      else                          s1_d.cls = CLS_NORM;
   end

   reg16_enc u_enc (
      .k      (s1_q.k),
      .regime (regime),
      .len    (reg_len)
   );

   // {e, mant} is slid in directly behind the variable-length regime.
   assign body_vec  = {regime, 49'd0} | ({s1_q.e, s1_q.mant, 40'd0} >> reg_len);
   assign body      = body_vec[63:49];
   assign guard     = body_vec[48];
   assign sticky    = |body_vec[47:0];
   assign rnd       = {1'b0, body} + {15'd0, guard & (body[0] | sticky)};
   assign exact_max = (s1_q.k == 7'sd14) && !s1_q.e && (s1_q.mant == '0);

   always_comb begin
      s2_d     = '0;
      s2_d.neg = s1_q.sign;
      case (s1_q.cls)
         CLS_NAR: begin
            s2_d.neg   = 1'b0;
            s2_d.mag   = P16_NAR;
            s2_d.flags = 3'b100;
         end
         CLS_ZERO: s2_d.neg = 1'b0;
         CLS_MAX: begin
            s2_d.mag   = P16_MAXPOS;
            s2_d.flags = {2'b01, !exact_max};
         end
         CLS_MIN: begin
            s2_d.mag   = P16_MINPOS;
            s2_d.flags = 3'b011;
         end
         default: begin
            if (rnd[15]) begin
               s2_d.mag   = P16_MAXPOS;
               s2_d.flags = {2'b01, guard | sticky};
            end else begin
               s2_d.mag   = rnd;
               s2_d.flags = {2'b00, guard | sticky};
            end
         end
      endcase
   end

   // NOTE: only valid bits and visible outputs take reset; the datapath records are don't-care until their valid bit is set.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         out_p16   <= '0;
         out_flags <= '0;
      end else if (adv) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
         if (v2) begin
            out_p16   <= s2_q.neg ? -s2_q.mag : s2_q.mag;
            out_flags <= s2_q.flags;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (adv && in_valid) s1_q <= s1_d;
      if (adv && v1)       s2_q <= s2_d;
   end

endmodule

// File: tb/tb_fp32_p161.sv
// Self-checking bench for fp32_p161: directed vectors, backpressure, full rate, mid-stall reset, random traffic.
module tb_fp32_p161;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_fp32;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_p16;
   logic [2:0]  out_flags;

   fp32_p161 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fp32   (in_fp32),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p16   (out_p16),
      .out_flags (out_flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [18:0] exp;
      int          cyc;
      bit          lat;
   } sb_t;

   sb_t         sb_q[$];
   sb_t         ent;
   int          out_cyc_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_out    = 0;
   int          cyc      = 0;
   int          rdy_mode = 0;
   logic [18:0] in_exp;
   bit          in_use_exp;
   bit          post_rst = 0;
   bit          held_v   = 0;
   logic [15:0] held_p16;
   logic [2:0]  held_flags;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: build the posit bit string literally (regime, e, mantissa), then round on it.
   function automatic logic [18:0] model(input logic [31:0] f);
      int          s, k, mag;
      bit          q[$];
      bit          g, st, sat, inx;
      logic [15:0] r;
      if (f[30:23] == 8'hFF) return {3'b100, 16'h8000};
      if (f[30:23] == 8'h00) return 19'd0;
      s   = int'(f[30:23]) - 127;
      sat = 0;
      inx = 0;
      if (s >= 28) begin
         mag = 32767; sat = 1; inx = !(s == 28 && f[22:0] == 23'd0);
      end else if (s < -28) begin
         mag = 1; sat = 1; inx = 1;
      end else begin
         k = (s >= 0) ? s / 2 : -((1 - s) / 2);
         if (k >= 0) begin
            repeat (k + 1) q.push_back(1'b1);
            q.push_back(1'b0);
         end else begin
            repeat (-k) q.push_back(1'b0);
            q.push_back(1'b1);
         end
         q.push_back(bit'(s - 2 * k));
         for (int i = 22; i >= 0; i--) q.push_back(f[i]);
         mag = 0;
         for (int i = 0; i < 15; i++) mag = mag * 2 + int'(q[i]);
         g  = q[15];
         st = 0;
         for (int i = 16; i < q.size(); i++) st |= q[i];
         inx = g | st;
         if (g && (mag % 2 == 1 || st)) mag++;
         if (mag > 32767) begin mag = 32767; sat = 1; end
      end
      r = f[31] ? 16'(65536 - mag) : 16'(mag);
      return {1'b0, sat, inx, r};
   endfunction

   function automatic logic [31:0] rand_fp32();
      logic [7:0] ex;
      int         sel;
      sel = $urandom_range(9);
      if (sel < 7)       ex = 8'($urandom_range(158, 95));
      else if (sel == 7) ex = 8'h00;
      else if (sel == 8) ex = 8'hFF;
      else               ex = 8'($urandom);
      return {1'($urandom), ex, 23'($urandom)};
   endfunction

   always @(posedge clk) cyc++;

   // Monitor: sample mid-cycle, predict the handshakes the next rising edge will perform.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         held_v   = 0;
         post_rst = 1;
      end else begin
         if (post_rst) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_p16", 32'(out_p16), 32'd0);
            check("rst_out_flags", 32'(out_flags), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            post_rst = 0;
         end
         if (held_v) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_p16", 32'(out_p16), 32'(held_p16));
            check("stall_flags", 32'(out_flags), 32'(held_flags));
         end
         check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
               ent = sb_q.pop_front();
               check("p16", 32'(out_p16), 32'(ent.exp[15:0]));
               check("flags", 32'(out_flags), 32'(ent.exp[18:16]));
               if (ent.lat) check("latency", 32'(cyc - ent.cyc), 32'd3);
            end
            n_out++;
            out_cyc_q.push_back(cyc);
         end
         held_v     = out_valid && !out_ready;
         held_p16   = out_p16;
         held_flags = out_flags;
         if (in_valid && in_ready) begin
            ent.exp = in_use_exp ? in_exp : model(in_fp32);
            ent.cyc = cyc;
            ent.lat = (rdy_mode == 0);
            sb_q.push_back(ent);
         end
      end
   end

   // out_ready driver: 0 always ready, 1 pattern 1,0,0, 2 random, 3 held low.
   initial begin
      int ph;
      ph        = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (ph == 0); ph = (ph == 2) ? 0 : ph + 1; end
            2: out_ready = ($urandom_range(3) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   task automatic send(input logic [31:0] v, input logic [18:0] exp, input bit use_exp);
      bit took;
      in_valid   = 1'b1;
      in_fp32    = v;
      in_exp     = exp;
      in_use_exp = use_exp;
      took       = 0;
      for (int i = 0; i < 200 && !took; i++) begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk); #1;
      end
      if (!took) check("accept_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int i = 0; i < 500 && sb_q.size() != 0; i++) begin @(posedge clk); #1; end
      check("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   logic [31:0] dir_in  [19] = '{
      32'h3F800000, 32'hBF800000, 32'h3FC00000, 32'h40000000, 32'h40800000,
      32'h3F800400, 32'h3F800401, 32'h3F800C00,
      32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h00000001,
      32'h7149F2CA, 32'h2B800000, 32'hAB800000,
      32'h4D800000, 32'hCD800000, 32'h4D000000, 32'h31800000};
   logic [18:0] dir_exp [19] = '{
      {3'b000, 16'h4000}, {3'b000, 16'hC000}, {3'b000, 16'h4800}, {3'b000, 16'h5000}, {3'b000, 16'h6000},
      {3'b001, 16'h4000}, {3'b001, 16'h4001}, {3'b001, 16'h4002},
      {3'b100, 16'h8000}, {3'b100, 16'h8000}, {3'b000, 16'h0000}, {3'b000, 16'h0000},
      {3'b011, 16'h7FFF}, {3'b011, 16'h0001}, {3'b011, 16'hFFFF},
      {3'b010, 16'h7FFF}, {3'b010, 16'h8001}, {3'b001, 16'h7FFE}, {3'b000, 16'h0001}};

   initial begin
      int n0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_fp32    = '0;
      in_exp     = '0;
      in_use_exp = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(2);

      // Directed values, streamed back to back at full rate.
      rdy_mode = 0;
      foreach (dir_in[i]) send(dir_in[i], dir_exp[i], 1);
      drain();

      // Backpressure: 8 items against a 1,0,0 ready pattern.
      rdy_mode = 1;
      n0 = n_out;
      for (int i = 0; i < 8; i++) send(rand_fp32(), '0, 0);
      drain();
      check("bp_count", 32'(n_out - n0), 32'd8);

      // Full rate: 16 inputs on consecutive cycles must leave on consecutive cycles.
      rdy_mode = 0;
      idle(2);
      out_cyc_q.delete();
      for (int i = 0; i < 16; i++) send(rand_fp32(), '0, 0);
      drain();
      check("fr_count", 32'(out_cyc_q.size()), 32'd16);
      if (out_cyc_q.size() == 16)
         check("fr_span", 32'(out_cyc_q[15] - out_cyc_q[0]), 32'd15);

      // Reset with three items in flight and the output stalled.
      rdy_mode = 3;
      idle(2);
      for (int i = 0; i < 3; i++) send(rand_fp32(), '0, 0);
      idle(2);
      check("pre_rst_stalled", 32'(out_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst      = 1'b0;
      rdy_mode = 0;
      n0       = n_out;
      idle(10);
      check("no_stale_after_rst", 32'(n_out - n0), 32'd0);

      // Random traffic with random gaps and random backpressure.
      rdy_mode = 2;
      for (int i = 0; i < 300; i++) begin
         send(rand_fp32(), '0, 0);
         if ($urandom_range(3) == 0) idle($urandom_range(2, 1));
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
